// File: rtl/idelay_pkg.sv
// idelay_pkg: shared widths, constants and sequencer state encoding
package idelay_pkg;
    localparam int TAP_W = 5;
    localparam int DLY_MIN_RST_NS = 52;
    typedef enum logic [2:0] {RESET_HOLD, WAIT_RDY, RUN, LOAD, SETTLE, FAULT} state_t;
endpackage

// File: rtl/idelay_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest requesting index at or after ptr
module rr_arbiter #(
    parameter int LANES = 4,
    parameter int PW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [LANES-1:0] grant,
    output logic [PW-1:0]    idx
);
    logic          found;
    logic [PW-1:0] j;
    // scan lanes starting at ptr with wraparound, keep the first hit
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        j = '0;
        for (int i = 0; i < LANES; i++) begin
            j = PW'((int'(ptr) + i) % LANES);
            if (!found && req[j]) begin
                found = 1'b1;
                grant[j] = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/idelay_sequencer.sv
// idelay_sequencer: IDELAYCTRL bring-up with lock supervision and round-robin IDELAYE2 tap loading
module idelay_sequencer
    import idelay_pkg::*;
#(
    parameter int LANES = 4,
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   dly_rst,
    input  logic                   dly_rdy,
    output logic                   ready,
    output logic                   fault,
    input  logic [LANES-1:0]       req_valid,
    input  logic [TAP_W*LANES-1:0] req_tap,
    output logic [LANES-1:0]       req_ready,
    output logic [TAP_W-1:0]       cntvaluein,
    output logic [LANES-1:0]       ld
);
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(RST_CYCLES + TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [RW-1:0]    retry, retry_n;
    logic [PW-1:0]    ptr, ptr_n, gi;
    logic [LANES-1:0] grant, sel, sel_n;
    logic [TAP_W-1:0] tap_g, tap_n;
    logic             rdy_m, rdy_s;

    // two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk or posedge rst)
        if (rst) {rdy_s, rdy_m} <= 2'b00;
        else {rdy_s, rdy_m} <= {rdy_m, dly_rdy};

    rr_arbiter #(.LANES(LANES), .PW(PW)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .grant(grant),
        .idx(gi)
    );

    // outputs decode straight from state so async reset reaches them at once
    assign dly_rst = (state == RESET_HOLD) || (state == FAULT);
    assign ready = (state == RUN) || (state == LOAD) || (state == SETTLE);
    assign fault = state == FAULT;
    assign req_ready = (state == RUN && rdy_s) ? grant : '0;
    assign ld = (state == LOAD) ? sel : '0;

    // tap of the currently granted lane
    always_comb begin
        tap_g = '0;
        for (int i = 0; i < LANES; i++)
            if (grant[i]) tap_g = req_tap[i*TAP_W +: TAP_W];
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RESET_HOLD;
            cnt <= '0;
            retry <= '0;
            ptr <= '0;
            sel <= '0;
            cntvaluein <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            retry <= retry_n;
            ptr <= ptr_n;
            sel <= sel_n;
            cntvaluein <= tap_n;
        end

    // next state; lock loss overrides everything, including a same-cycle accept
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        retry_n = retry;
        ptr_n = ptr;
        sel_n = sel;
        tap_n = cntvaluein;
        case (state)
            RESET_HOLD: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_n = WAIT_RDY;
                    cnt_n = '0;
                end
            end
            WAIT_RDY: begin
                cnt_n = cnt + 1'b1;
                if (rdy_s) begin
                    state_n = RUN;
                    retry_n = '0;
                    cnt_n = '0;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_n = '0;
                    retry_n = retry + 1'b1;
                    state_n = (retry_n == RW'(MAX_RETRIES)) ? FAULT : RESET_HOLD;
                end
            end
            RUN:
                if (|req_valid) begin
                    state_n = LOAD;
                    sel_n = grant;
                    tap_n = tap_g;
                    ptr_n = (gi == PW'(LANES - 1)) ? '0 : gi + 1'b1;
                end
            LOAD: begin
                state_n = SETTLE;
                cnt_n = '0;
            end
            SETTLE: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_n = RUN;
                    cnt_n = '0;
                end
            end
            default: state_n = FAULT;
        endcase
        if (!rdy_s && ready) begin
            state_n = RESET_HOLD;
            cnt_n = '0;
            retry_n = '0;
            ptr_n = ptr;
            sel_n = sel;
            tap_n = cntvaluein;
        end
    end
endmodule

// File: tb/tb_idelay_sequencer.sv
// tb_idelay_sequencer: bring-up, retry/fault, round-robin loading, lock loss and async reset checks
module tb_idelay_sequencer;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst, dly_rst, dly_rdy, ready, fault;
    logic [L-1:0]   req_valid, req_ready, ld;
    logic [5*L-1:0] req_tap;
    logic [4:0]     cntvaluein;

    int n_checks = 0;
    int n_pass = 0;

    logic [L-1:0] v, add_mask, last_g, served, pend;
    logic [4:0]   taps [L];
    logic [4:0]   last_tap;
    int           mptr, busy, acc, cyc;
    logic [L-1:0] ld_obs [$];
    int           ld_cyc [$];

    always #5 clk = ~clk;

    assign req_valid = v;
    always_comb begin
        req_tap = '0;
        for (int i = 0; i < L; i++) req_tap[5*i +: 5] = taps[i];
    end

    idelay_sequencer #(
        .LANES(L), .RST_CYCLES(16), .TIMEOUT_CYCLES(1024), .MAX_RETRIES(3), .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .dly_rst(dly_rst), .dly_rdy(dly_rdy), .ready(ready), .fault(fault),
        .req_valid(req_valid), .req_tap(req_tap), .req_ready(req_ready),
        .cntvaluein(cntvaluein), .ld(ld)
    );

    function automatic int pick(logic [L-1:0] m, int p);
        for (int i = 0; i < L; i++)
            if (m[(p + i) % L]) return (p + i) % L;
        return -1;
    endfunction

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (dly_rst === lvl && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_lock(input int delay, input string name);
        int n;
        repeat (delay) @(negedge clk);
        dly_rdy = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (ready !== 1'b1 || n > 3) $display("FAIL %s_lock ready=%b after %0d cycles, need 1 within 3", name, ready, n);
        else n_pass++;
        n_checks++;
        if (fault !== 1'b0 || dly_rst !== 1'b0) $display("FAIL %s_flags fault=%b dly_rst=%b, need 0 0", name, fault, dly_rst);
        else n_pass++;
        busy = 0;
        acc = -1;
    endtask

    // one cycle of requester behaviour plus the transaction-level expectation
    task automatic step(input int mode, input bit w);
        int g;
        logic [L-1:0] exp_rr, exp_ld;
        if (w) @(negedge clk);
        if (acc >= 0) begin
            if (mode != 1) v[acc] = 1'b0;
            acc = -1;
        end
        v = v | add_mask;
        add_mask = '0;
        if (mode == 0)
            for (int i = 0; i < L; i++)
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    taps[i] = 5'($urandom_range(0, 31));
                    v[i] = 1'b1;
                end
        #1;
        if (ld !== '0) begin
            ld_obs.push_back(ld);
            ld_cyc.push_back(cyc);
        end
        served = served | ld;
        g = (busy == 0) ? pick(v, mptr) : -1;
        exp_rr = '0;
        if (g >= 0) exp_rr[g] = 1'b1;
        exp_ld = (busy == 3) ? last_g : '0;
        n_checks++;
        if (req_ready !== exp_rr) $display("FAIL grant cyc=%0d req_ready=%b need %b", cyc, req_ready, exp_rr);
        else n_pass++;
        n_checks++;
        if (ld !== exp_ld) $display("FAIL ld cyc=%0d ld=%b need %b", cyc, ld, exp_ld);
        else n_pass++;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL run_ready cyc=%0d ready=%b need 1", cyc, ready);
        else n_pass++;
        if (busy == 3) begin
            n_checks++;
            if (cntvaluein !== last_tap) $display("FAIL tap cyc=%0d cntvaluein=%0d need %0d", cyc, cntvaluein, last_tap);
            else n_pass++;
        end
        if (busy > 0) busy--;
        else if (g >= 0) begin
            last_g = exp_rr;
            last_tap = taps[g];
            mptr = (g + 1) % L;
            busy = 3;
            acc = g;
        end
        cyc++;
    endtask

    task automatic test_reset();
        v = '1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({dly_rst, ready, fault} !== 3'b100) $display("FAIL reset_flags dly_rst/ready/fault=%b need 100", {dly_rst, ready, fault});
        else n_pass++;
        n_checks++;
        if ({req_ready, ld, cntvaluein} !== '0) $display("FAIL reset_outs req_ready=%b ld=%b tap=%0d need 0", req_ready, ld, cntvaluein);
        else n_pass++;
        v = '0;
    endtask

    task automatic test_nominal();
        int n;
        @(negedge clk);
        rst = 1'b0;
        measure(1'b1, n);
        n_checks++;
        if (n != 16) $display("FAIL nominal_rst_len got %0d cycles need 16", n);
        else n_pass++;
        wait_lock(40, "nominal");
    endtask

    task automatic test_round_robin();
        logic [L-1:0] eo [5];
        eo = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        taps[0] = 5'd3; taps[1] = 5'd7; taps[2] = 5'd11; taps[3] = 5'd31;
        ld_obs.delete();
        ld_cyc.delete();
        add_mask = '1;
        repeat (20) step(1, 1'b1);
        n_checks++;
        if (ld_obs.size() < 5) $display("FAIL rr_count got %0d loads need >=5", ld_obs.size());
        else begin
            n_pass++;
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (ld_obs[k] !== eo[k]) $display("FAIL rr_order load %0d ld=%b need %b", k, ld_obs[k], eo[k]);
                else n_pass++;
                if (k > 0) begin
                    n_checks++;
                    if (ld_cyc[k] - ld_cyc[k-1] != 4) $display("FAIL rr_spacing load %0d gap=%0d need 4", k, ld_cyc[k] - ld_cyc[k-1]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < L; i++) if (!v[i]) taps[i] = 5'($urandom_range(0, 31));
        add_mask = L'($urandom_range(1, 15));
        repeat (300) step(0, 1'b1);
    endtask

    task automatic test_lock_loss();
        int n;
        bit bad;
        for (int i = 0; i < L; i++) if (!v[i]) taps[i] = 5'($urandom_range(0, 31));
        add_mask = '1;
        n = 0;
        do begin
            step(2, 1'b1);
            n++;
        end while (busy != 1 && n < 20);
        pend = v;
        dly_rdy = 1'b0;
        n = 0;
        bad = 0;
        while (ready === 1'b1 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
            if (ld !== '0 || req_ready !== '0) bad = 1;
        end
        n_checks++;
        if (ready !== 1'b0 || n > 3) $display("FAIL loss_ready ready=%b after %0d cycles need 0 within 3", ready, n);
        else n_pass++;
        n_checks++;
        if (bad) $display("FAIL loss_quiet ld or req_ready pulsed during lock loss, need none");
        else n_pass++;
        measure(1'b1, n);
        n_checks++;
        if (n != 16) $display("FAIL loss_rst_len got %0d cycles need 16", n);
        else n_pass++;
        wait_lock(40, "relock");
        served = '0;
        step(2, 1'b0);
        repeat (40) step(2, 1'b1);
        n_checks++;
        if (served !== pend) $display("FAIL loss_pending served=%b need %b", served, pend);
        else n_pass++;
    endtask

    task automatic test_async_reset_load();
        int n;
        taps[2] = 5'd19;
        add_mask = 4'b0100;
        n = 0;
        do begin
            step(2, 1'b1);
            n++;
        end while (busy != 2 && n < 20);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dly_rst, ready, fault} !== 3'b100) $display("FAIL areset_flags dly_rst/ready/fault=%b need 100", {dly_rst, ready, fault});
        else n_pass++;
        n_checks++;
        if ({ld, req_ready, cntvaluein} !== '0) $display("FAIL areset_outs ld=%b req_ready=%b tap=%0d need 0", ld, req_ready, cntvaluein);
        else n_pass++;
        v = '0;
        acc = -1;
        busy = 0;
        mptr = 0;
    endtask

    task automatic test_timeout();
        int n;
        dly_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 3; a++) begin
            measure(1'b1, n);
            n_checks++;
            if (n != 16) $display("FAIL timeout_pulse%0d got %0d cycles need 16", a, n);
            else n_pass++;
            measure(1'b0, n);
            n_checks++;
            if (n != 1024) $display("FAIL timeout_gap%0d got %0d cycles need 1024", a, n);
            else n_pass++;
        end
        #1;
        n_checks++;
        if ({fault, dly_rst, ready} !== 3'b110) $display("FAIL fault_entry fault/dly_rst/ready=%b need 110", {fault, dly_rst, ready});
        else n_pass++;
        dly_rdy = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        n_checks++;
        if ({fault, dly_rst, ready, req_ready, ld} !== {3'b110, 8'h00}) $display("FAIL fault_sticky fault/dly_rst/ready=%b need 110", {fault, dly_rst, ready});
        else n_pass++;
    endtask

    task automatic test_retry_recovery();
        int n;
        rst = 1'b1;
        dly_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        measure(1'b1, n);
        n_checks++;
        if (n != 16) $display("FAIL recover_pulse0 got %0d cycles need 16", n);
        else n_pass++;
        measure(1'b0, n);
        n_checks++;
        if (n != 1024) $display("FAIL recover_gap got %0d cycles need 1024", n);
        else n_pass++;
        measure(1'b1, n);
        n_checks++;
        if (n != 16) $display("FAIL recover_pulse1 got %0d cycles need 16", n);
        else n_pass++;
        wait_lock(100, "recover");
    endtask

    initial begin
        rst = 1'b1;
        dly_rdy = 1'b0;
        v = '0;
        add_mask = '0;
        served = '0;
        pend = '0;
        last_g = '0;
        last_tap = '0;
        mptr = 0;
        busy = 0;
        acc = -1;
        cyc = 0;
        for (int i = 0; i < L; i++) taps[i] = 5'($urandom_range(0, 31));
        test_reset();
        test_nominal();
        test_round_robin();
        test_random();
        test_lock_loss();
        test_async_reset_load();
        test_timeout();
        test_retry_recovery();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
